opacc_seq: RTL

- Command-driven sequencer for the outer-product accumulator (opacc) datapath. Replaces the bare two-flag shift controller.
- Runs one complete tile operation per command: load or clear C, apply K rank-1 A/B updates, drain C rows.
- Sits between the vector issue/writeback logic and opacc. Every transfer uses a valid/ready handshake, and the block drives opacc's en_c/en_ab enables directly.

---
 rtl/opacc_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/opacc_seq.sv
// opacc_seq: command sequencer driving opacc through load/clear, K rank-1 updates and C drain
module opacc_seq #(
  parameter int ML = 2,
  parameter int KW = 8,
  parameter int RW = (ML > 1) ? $clog2(ML) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load_c,
  input  logic [KW-1:0] cmd_k,
  input  logic          abort,
  input  logic          c_in_valid,
  output logic          c_in_ready,
  input  logic          ab_valid,
  output logic          ab_ready,
  output logic          c_out_valid,
  input  logic          c_out_ready,
  output logic          en_c,
  output logic          en_ab,
  output logic          clr_c,
  output logic [RW-1:0] row_sel,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, LOAD_C, CLEAR, ACC, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [RW-1:0] row_cnt, row_nx;
  logic [KW-1:0] k_cnt, k_nx, k_reg;
  logic last_row, last_k, k_zero, accept;
  assign last_row = row_cnt == RW'(ML - 1);
  assign last_k = k_cnt == k_reg - KW'(1);
  assign k_zero = k_reg == '0;
  assign accept = cmd_ready & cmd_valid;
  always_comb begin
    state_nx = state;
    row_nx = row_cnt;
    k_nx = k_cnt;
    cmd_ready = 1'b0;
    c_in_ready = 1'b0;
    ab_ready = 1'b0;
    c_out_valid = 1'b0;
    en_c = 1'b0;
    en_ab = 1'b0;
    clr_c = 1'b0;
    row_sel = '0;
    done = 1'b0;
    busy = state != IDLE;
    case (state)
      IDLE: begin
        cmd_ready = ~abort;
        if (cmd_valid && !abort) begin
          row_nx = '0;
          k_nx = '0;
          state_nx = cmd_load_c ? LOAD_C : CLEAR;
        end
      end
      LOAD_C: begin
        c_in_ready = 1'b1;
        row_sel = row_cnt;
        en_c = c_in_valid;
        if (c_in_valid) begin
          row_nx = last_row ? '0 : row_cnt + RW'(1);
          state_nx = !last_row ? LOAD_C : k_zero ? DRAIN : ACC;
        end
      end
      CLEAR: begin
        clr_c = 1'b1;
        state_nx = k_zero ? DRAIN : ACC;
      end
      ACC: begin
        ab_ready = 1'b1;
        en_ab = ab_valid;
        // k_cnt parks on k_reg-1 at the final update rather than overshooting
        if (ab_valid) begin
          k_nx = last_k ? k_cnt : k_cnt + KW'(1);
          state_nx = last_k ? DRAIN : ACC;
        end
      end
      DRAIN: begin
        c_out_valid = 1'b1;
        row_sel = row_cnt;
        en_c = c_out_ready;
        if (c_out_ready) begin
          row_nx = last_row ? '0 : row_cnt + RW'(1);
          state_nx = last_row ? DONE : DRAIN;
        end
      end
      DONE: begin
        done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // abort also withdraws ready/valid so no beat is handshaken and then dropped
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      row_nx = '0;
      k_nx = '0;
      c_in_ready = 1'b0;
      ab_ready = 1'b0;
      c_out_valid = 1'b0;
      en_c = 1'b0;
      en_ab = 1'b0;
      clr_c = 1'b0;
      done = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      row_cnt <= '0;
      k_cnt <= '0;
      k_reg <= '0;
    end else begin
      state <= state_nx;
      row_cnt <= row_nx;
      k_cnt <= k_nx;
      if (accept) k_reg <= cmd_k;
    end
  end
endmodule
